// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg
// Shared types and constants for the multi_decade_counter control path.
//   seq_state_t    : load sequencer states (IDLE / CHECK / LOAD / DONE)
//   DIGIT_W        : width of one counter digit
//   MODE_DEC/HEX   : encodings of the counter mode input
//   DIR_UP         : encoding of "count up" on the counter updown input
//   digit_invalid(): true when a digit cannot be held by a decimal counter
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int   DIGIT_W  = 4;
    localparam logic MODE_DEC = 1'b1;
    localparam logic MODE_HEX = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // A digit above 9 is only a problem when the counter wraps decimally.
    function automatic logic digit_invalid(input logic mode, input logic [DIGIT_W-1:0] d);
        return (mode != MODE_HEX) && (d > DIGIT_W'(9));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
// Free-running divider that produces the counter's count-enable tick.
// Ports:
//   clk     in  system clock, rising edge
//   reset_n in  asynchronous active-low reset (count -> 0)
//   en      in  advance the count this cycle; the count holds when low
//   clr     in  synchronous clear of the count (has priority over en)
//   tick    out high for the single enabled cycle at count TICK_DIV-1
// Parameter TICK_DIV (>= 1): cycles per tick; 1 gives a tick every enabled cycle.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Gated by en so a count parked at LAST while stopped never fires a tick.
    assign tick = en && !clr && (count_q == LAST);

endmodule

// File: rtl/cnt_load_sequencer.sv
// cnt_load_sequencer
// Drives every control input of multi_decade_counter: count-enable tick,
// run/stop, mode, direction, and a digit-per-clock preset load sequence.
// Ports:
//   clk, reset_n          clock (rising edge) and asynchronous active-low reset
//   start                 one-cycle load request, honoured only while idle
//   preset[15:0]          four digits, digit0 = [3:0] .. digit3 = [15:12]
//   run                   1 = counting allowed
//   mode_in, updown_in    requested counter mode (1 = decimal) and direction (1 = up)
//   busy, done, err       sequence in progress / end pulse / sticky bad-preset flag
//   cnt_enable, cnt_mode, cnt_updown, cnt_load, cnt_an_sel, cnt_load_count
//                         registered drives for the counter's control port
// Build option: define CNT_SEQ_VALIDATE_EN to enable the decimal range check
// and the err flag; without it every preset is loaded and err stays 0.
module cnt_load_sequencer
    import cnt_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [DIGITS*DIGIT_W-1:0]   preset,
    input  logic                        run,
    input  logic                        mode_in,
    input  logic                        updown_in,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        cnt_enable,
    output logic                        cnt_mode,
    output logic                        cnt_updown,
    output logic                        cnt_load,
    output logic [1:0]                  cnt_an_sel,
    output logic [DIGIT_W-1:0]          cnt_load_count
);

    localparam logic [1:0] LAST_IDX = 2'(DIGITS - 1);

    seq_state_t                  state_q, state_d;
    logic [DIGITS*DIGIT_W-1:0]   preset_q, preset_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;
    logic                        cnt_enable_q, cnt_enable_d;
    logic                        cnt_mode_q, cnt_mode_d;
    logic                        cnt_updown_q, cnt_updown_d;
    logic                        cnt_load_q, cnt_load_d;
    logic [1:0]                  an_sel_q, an_sel_d;
    logic [DIGIT_W-1:0]          load_count_q, load_count_d;

    logic                        tick;
    logic                        preset_invalid;
    logic [1:0]                  next_idx;
    logic [DIGIT_W-1:0]          digit [DIGITS];

    // Prescaler only advances while counting is actually possible, and is
    // cleared at the end of every sequence so the first post-load tick is a
    // full period away.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (run && (state_q == IDLE)),
        .clr     (state_q == DONE),
        .tick    (tick)
    );

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign digit[gi] = preset_q[gi*DIGIT_W +: DIGIT_W];
    end

`ifdef CNT_SEQ_VALIDATE_EN
    logic [DIGITS-1:0] digit_bad;
    // cnt_mode_q is frozen outside IDLE, so it is the mode captured with start.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
        assign digit_bad[gi] = digit_invalid(cnt_mode_q, digit[gi]);
    end
    assign preset_invalid = |digit_bad;
`else
    assign preset_invalid = 1'b0;
`endif

    assign next_idx = an_sel_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        preset_d     = preset_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        cnt_enable_d = 1'b0;
        cnt_mode_d   = cnt_mode_q;
        cnt_updown_d = cnt_updown_q;
        cnt_load_d   = 1'b0;
        an_sel_d     = '0;
        load_count_d = '0;

        case (state_q)
            IDLE: begin
                cnt_mode_d   = mode_in;
                cnt_updown_d = updown_in;
                if (start) begin
                    preset_d = preset;
                    busy_d   = 1'b1;
                    state_d  = CHECK;
                end else begin
                    // A tick coinciding with start is dropped so enable never
                    // shows up while busy.
                    cnt_enable_d = tick && run;
                end
            end
            CHECK: begin
                err_d = preset_invalid;
                if (preset_invalid) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_load_d   = 1'b1;
                    an_sel_d     = '0;
                    load_count_d = digit[0];
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                if (an_sel_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_load_d   = 1'b1;
                    an_sel_d     = next_idx;
                    load_count_d = digit[next_idx];
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            preset_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cnt_enable_q <= 1'b0;
            cnt_mode_q   <= MODE_DEC;
            cnt_updown_q <= DIR_UP;
            cnt_load_q   <= 1'b0;
            an_sel_q     <= '0;
            load_count_q <= '0;
        end else begin
            state_q      <= state_d;
            preset_q     <= preset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cnt_enable_q <= cnt_enable_d;
            cnt_mode_q   <= cnt_mode_d;
            cnt_updown_q <= cnt_updown_d;
            cnt_load_q   <= cnt_load_d;
            an_sel_q     <= an_sel_d;
            load_count_q <= load_count_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign cnt_enable     = cnt_enable_q;
    assign cnt_mode       = cnt_mode_q;
    assign cnt_updown     = cnt_updown_q;
    assign cnt_load       = cnt_load_q;
    assign cnt_an_sel     = an_sel_q;
    assign cnt_load_count = load_count_q;

endmodule

// File: tb/tb_cnt_load_sequencer.sv
// tb_cnt_load_sequencer
// Scoreboarded bench: stimulus pushes the expected load beats and done pulse
// of every accepted start (with their cycle numbers) into a queue; a monitor
// pops and compares whenever the DUT shows cnt_load or done.
module tb_cnt_load_sequencer;

    localparam int TICK_DIV = 4;
`ifdef CNT_SEQ_VALIDATE_EN
    localparam bit VALIDATE = 1'b1;
`else
    localparam bit VALIDATE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] preset;
    logic        run;
    logic        mode_in;
    logic        updown_in;
    logic        busy, done, err;
    logic        cnt_enable, cnt_mode, cnt_updown, cnt_load;
    logic [1:0]  cnt_an_sel;
    logic [3:0]  cnt_load_count;

    cnt_load_sequencer #(
        .DIGITS   (4),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .preset         (preset),
        .run            (run),
        .mode_in        (mode_in),
        .updown_in      (updown_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .cnt_enable     (cnt_enable),
        .cnt_mode       (cnt_mode),
        .cnt_updown     (cnt_updown),
        .cnt_load       (cnt_load),
        .cnt_an_sel     (cnt_an_sel),
        .cnt_load_count (cnt_load_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit   is_done;
        int   an;
        int   dig;
        int   err;
        int   at_cyc;
        int   busy_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                      name, act, act, req, req, cyc);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s at cycle %0d", name, what, cyc);
    endtask

    // Reference model: what an accepted start at cycle c must produce.
    task automatic model_start(input logic [15:0] p, input bit dec, input int c);
        bit   bad = 0;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (VALIDATE && dec && (((p >> (4 * k)) & 16'hF) > 9)) bad = 1;
        end
        if (bad) begin
            e = '{1'b1, 0, 0, 1, c + 2, 2};
            exp_q.push_back(e);
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = '{1'b0, k, int'((p >> (4 * k)) & 16'hF), 0, c + 2 + k, 0};
                exp_q.push_back(e);
            end
            e = '{1'b1, 0, 0, 0, c + 6, 6};
            exp_q.push_back(e);
        end
        $display("start preset=%h mode=%0d cycle=%0d expect %s", p, dec, c,
                 bad ? "reject" : "load");
    endtask

    // Monitor
    initial begin
        int   busy_run = 0;
        int   en_bad   = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_run = 0;
                en_bad   = 0;
            end else begin
                if (busy) busy_run++;
                if (busy && cnt_enable) en_bad++;
                if (cnt_load) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_load", $sformatf("an_sel=%0d load_count=%h, expected none",
                                 cnt_an_sel, cnt_load_count));
                    end else begin
                        e = exp_q.pop_front();
                        $display("load an_sel=%0d load_count=%h cycle=%0d", cnt_an_sel, cnt_load_count, cyc);
                        chk("load_kind", 0, int'(e.is_done));
                        chk("load_an_sel", int'(cnt_an_sel), e.an);
                        chk("load_count", int'(cnt_load_count), e.dig);
                        chk("load_cycle", cyc, e.at_cyc);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_done", "done pulse, expected none");
                    end else begin
                        e = exp_q.pop_front();
                        $display("done err=%0d busy_len=%0d cycle=%0d", err, busy_run, cyc);
                        chk("done_kind", 1, int'(e.is_done));
                        chk("done_err", int'(err), e.err);
                        chk("done_cycle", cyc, e.at_cyc);
                        chk("busy_len", busy_run, e.busy_len);
                        chk("enable_while_busy", en_bad, 0);
                    end
                end
                if (!busy) begin
                    busy_run = 0;
                    en_bad   = 0;
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] p, input bit dec);
        @(negedge clk);
        if (busy) fail_now("start_not_idle", "DUT busy when issuing start");
        preset  = p;
        mode_in = dec;
        start   = 1'b1;
        model_start(p, dec, cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("idle_timeout", "sequence did not complete in 100 cycles");
    endtask

    task automatic wait_load(input int an);
        int k = 0;
        while (!(cnt_load && cnt_an_sel == 2'(an)) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) fail_now("load_timeout", $sformatf("load beat %0d not seen", an));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, last, gap_bad, k, bad;
        logic [15:0] p;

        reset_n = 1'b0; start = 1'b0; preset = '0;
        run = 1'b1; mode_in = 1'b1; updown_in = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_an_sel", int'(cnt_an_sel), 0);
        chk("rst_load_count", int'(cnt_load_count), 0);
        chk("rst_mode", int'(cnt_mode), 1);
        chk("rst_updown", int'(cnt_updown), 1);
        reset_n = 1'b1;

        // Tick: one enable pulse every TICK_DIV cycles
        pulses = 0; last = -1; gap_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (cnt_enable) begin
                if (last >= 0 && cyc - last != TICK_DIV) gap_bad++;
                last = cyc;
                pulses++;
            end
        end
        $display("tick window pulses=%0d gap_errors=%0d", pulses, gap_bad);
        chk("tick_pulses", pulses, 40 / TICK_DIV);
        chk("tick_gaps", gap_bad, 0);
        chk("idle_mode", int'(cnt_mode), 1);
        chk("idle_updown", int'(cnt_updown), 1);

        // run=0 holds the prescaler; resuming gives a full period
        k = 0;
        while (!cnt_enable && k < 10) begin @(negedge clk); k++; end
        run = 1'b0;
        pulses = 0;
        repeat (12) begin @(negedge clk); if (cnt_enable) pulses++; end
        chk("run0_no_enable", pulses, 0);
        run = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!cnt_enable && k < 10);
        $display("run resume: first enable after %0d cycles", k);
        chk("run_resume_gap", k, TICK_DIV);

        // Directed sequences
        do_start(16'h4321, 1'b1); wait_idle();
        do_start(16'h00E0, 1'b1); wait_idle();
        chk("err_sticky_idle", int'(err), VALIDATE ? 1 : 0);
        do_start(16'h00E0, 1'b0); wait_idle();
        chk("err_cleared", int'(err), 0);

        // start during 3rd load beat is ignored
        do_start(16'h9876, 1'b1);
        wait_load(2);
        preset = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // direction frozen while busy, picked up after DONE
        updown_in = 1'b1;
        @(negedge clk);
        do_start(16'h1234, 1'b1);
        wait_load(1);
        updown_in = 1'b0;
        bad = 0; k = 0;
        do begin
            @(negedge clk); k++;
            if (cnt_updown !== 1'b1) bad++;
        end while (!done && k < 20);
        chk("updown_frozen", bad, 0);
        wait_idle();
        chk("updown_after_done", int'(cnt_updown), 1);
        @(negedge clk);
        chk("updown_picked_up", int'(cnt_updown), 0);
        updown_in = 1'b1;
        wait_idle();

        // reset during the 2nd load beat
        do_start(16'h5678, 1'b1);
        wait_load(1);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_load", int'(cnt_load), 0);
        chk("arst_an_sel", int'(cnt_an_sel), 0);
        chk("arst_load_count", int'(cnt_load_count), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_mode", int'(cnt_mode), 1);
        chk("arst_updown", int'(cnt_updown), 1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_idle_busy", int'(busy), 0);
        do_start(16'h0259, 1'b1); wait_idle();

        // Randomized sequences
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run       = 1'($urandom_range(0, 1));
            updown_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int d = 0; d < 4; d++) p[4*d +: 4] = 4'($urandom_range(0, 9));
            end else begin
                p = 16'($urandom_range(0, 65535));
            end
            do_start(p, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                if (busy) begin
                    preset = 16'($urandom_range(0, 65535));
                    start  = 1'b1;
                    @(negedge clk);
                    start  = 1'b0;
                end
            end
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnt_load_sequencer.md
# cnt_load_sequencer

Controller that sits in front of `multi_decade_counter` and drives all of its control inputs. It generates the count-enable tick from a prescaler, applies run/stop, mode and direction, and, on a start request, loads a 16-bit four-digit preset into the counter one digit per clock over the `load` / `an_sel` / `load_count` port. It reports progress with a busy/done handshake and flags presets that are illegal in decimal mode.

## Interface
- `DIGITS`, 4: number of counter digits loaded per sequence; fixed at 4 for `multi_decade_counter`.
- `TICK_DIV`, 100_000_000: clock cycles per count tick; must be ≥1, and 1 means a tick every cycle.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to load `preset`; accepted only in IDLE.
- `preset` in 16: digit0 = [3:0] … digit3 = [15:12].
- `run` in 1: 1 = counting allowed.
- `mode_in` in 1: 1 = decimal (0–9 wrap), 0 = hex.
- `updown_in` in 1: 1 = up, 0 = down.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse at the end of a sequence.
- `err` out 1: sticky invalid-preset flag.
- `cnt_enable` out 1: drives counter `enable`.
- `cnt_mode` out 1: drives counter `mode`.
- `cnt_updown` out 1: drives counter `updown`.
- `cnt_load` out 1: drives counter `load`.
- `cnt_an_sel` out 2: drives counter `an_sel`.
- `cnt_load_count` out 4: drives counter `load_count`.

## Operation
- States are IDLE, CHECK, LOAD and DONE.
- IDLE
  - `cnt_mode` and `cnt_updown` register `mode_in` and `updown_in` every cycle.
  - `cnt_enable` = tick & `run`.
  - `start` latches `preset` and goes to CHECK.
- CHECK (1 cycle)
  - A digit is invalid if `cnt_mode`=1 and the digit value is >9.
  - If any digit is invalid: `err`←1, no load is issued, go to DONE.
  - Otherwise `err`←0 and go to LOAD.
- LOAD (DIGITS cycles)
  - `cnt_load`=1 and `cnt_an_sel`=k for k=0..3 in order.
  - `cnt_load_count` = latched digit k.
  - The digit index wraps to 0 after 3, then go to DONE.
- DONE (1 cycle)
  - `done`=1 and the prescaler is cleared; return to IDLE.
- While not in IDLE:
  - `cnt_enable`=0.
  - `cnt_mode` and `cnt_updown` are frozen; changes to `mode_in`/`updown_in` are picked up on return to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor latched.
- `err` holds until the next CHECK.
- Prescaler: counts 0..TICK_DIV-1 only while `run`=1 in IDLE, and holds while `run`=0. The tick is high for the single cycle at TICK_DIV-1, after which the count wraps to 0.

## Timing
- Reset values:
  - State IDLE; prescaler 0.
  - `busy`, `done`, `err`, `cnt_enable`, `cnt_load` = 0.
  - `cnt_an_sel`=0, `cnt_load_count`=0.
  - `cnt_mode`=1, `cnt_updown`=1.
- All outputs are registered.
- `start` sampled at edge N:
  - `busy`=1 from N+1 to N+6.
  - CHECK occurs in N+1.
  - Load cycles occur in N+2..N+5.
  - `done` occurs in N+6; IDLE resumes at N+7.
- Invalid preset: CHECK in N+1, `done` in N+2, `busy`=1 in N+1..N+2.
- First tick after a load: TICK_DIV cycles after returning to IDLE with `run`=1.
- `reset_n` low mid-sequence:
  - All outputs clear immediately (asynchronous reset).
  - A partial load is not resumed, and `done` is not pulsed.

## Configuration
- `CNT_SEQ_VALIDATE_EN` defined:
  - CHECK performs the decimal range check.
  - `err` is live as described in Operation.
- `CNT_SEQ_VALIDATE_EN` undefined:
  - CHECK always passes, so every preset is loaded unmodified.
  - `err` is tied to 0.
  - Latency is unchanged; the CHECK cycle is kept.

## Structure
- Package `cnt_ctrl_pkg` holds:
  - The state enumeration (IDLE/CHECK/LOAD/DONE).
  - `DIGIT_W`=4.
  - `MODE_DEC`=1'b1, `MODE_HEX`=1'b0.
  - `DIR_UP`=1'b1.
- Sub-module `tick_prescaler`:
  - Parameter `TICK_DIV`.
  - Inputs `clk`, `reset_n`, `en`, `clr`; output `tick`.
  - Instantiated once.

## Test plan
- Reset with `run`=1, `TICK_DIV`=4, then release `reset_n` → `cnt_enable` pulses one cycle in every 4; `cnt_mode`=1 and `cnt_updown`=1.
- `start` with `preset`=16'h4321 and `mode_in`=1 → `cnt_load` high for 4 cycles with `an_sel`/`load_count` = 0/1, 1/2, 2/3, 3/4; `done` 5 cycles after `busy` rises; counter reads 4321.
- `start` with `preset`=16'h00E0 and `mode_in`=1 → `err`=1, no `cnt_load` pulse, `done` 2 cycles after `start`. Same preset with `mode_in`=0 → load 0,E,0,0 and `err`=0.
- `start` pulsed again in the 3rd LOAD cycle → ignored; exactly 4 load cycles occur and a single `done`.
- Toggle `updown_in` 1→0 during LOAD → `cnt_updown` stays 1 until the cycle after DONE, then 0. `run`=0 → `cnt_enable` stays 0 and the prescaler holds.
- Assert `reset_n` low during the 2nd LOAD cycle → all outputs 0 (`cnt_mode`/`cnt_updown` = 1) immediately, no `done`, and the controller is in IDLE after release.
